// File: rtl/lcrc32_stream.sv
// lcrc32_stream
//   Streaming LCRC-32 generator/checker. Packets arrive as DATA_W-bit beats on
//   a valid/ready handshake. The CRC of one beat is folded per cycle.
//   Generate mode (mode=0): payload is forwarded and N = 32/DATA_W CRC beats
//   are appended, with out_last on the final CRC beat.
//   Check mode (mode=1): the packet is forwarded unchanged. The trailing 32 bits
//   are compared against the CRC of everything before them, and a one-cycle
//   crc_done pulse is produced together with crc_err.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   mode       0 = generate/append, 1 = check (sampled on a packet's first beat)
//   in_valid   / in_ready  / in_data  / in_last   : input beat stream
//   out_valid  / out_ready / out_data / out_last  : output beat stream
//   crc_done   one-cycle pulse, check-mode verdict valid
//   crc_err    check-mode mismatch, held until the next crc_done
module lcrc32_stream #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              crc_done,
  output logic              crc_err
);

  localparam int N  = 32 / DATA_W;
  localparam int NB = DATA_W / 8;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  // Beat counter saturates at N+1: "at least one beat has been folded".
  localparam int KW = $clog2(N + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_APPEND = 2'd2
  } state_t;

  // Fold one beat: bytes MS first, bit 0 of each byte first.
  function automatic logic [31:0] crc_fold(input logic [31:0] c_in,
                                           input logic [DATA_W-1:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int j = NB - 1; j >= 0; j--) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[31] ^ d[8*j+i];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  // Wire-order LCRC: invert and bit-reverse within each byte.
  function automatic logic [31:0] crc_final(input logic [31:0] c);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*k+i] = ~c[8*k+7-i];
      end
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [31:0]       crc_q, crc_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     app_q, app_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Delay line: index 0 is the oldest beat, N-1 the newest.
  logic [DATA_W-1:0] dly_q     [N];
  logic [DATA_W-1:0] dly_shift [N];
  logic              dly_we;
  logic [31:0]       dly_next_flat;
  logic [DATA_W-1:0] crc_slice [N];

  logic              is_idle, eff_mode, accept, out_free, dly_full;
  logic [31:0]       base_crc, gen_crc, chk_crc, crc_fin;
  logic [KW-1:0]     base_cnt, chk_cnt;

  assign is_idle  = (state_q == S_IDLE);
  assign eff_mode = is_idle ? mode : mode_q;
  // A packet starting this cycle sees a fresh seed and an empty delay line.
  assign base_crc = is_idle ? SEED : crc_q;
  assign base_cnt = is_idle ? '0 : cnt_q;
  assign dly_full = (base_cnt >= KW'(N));

  assign gen_crc  = crc_fold(base_crc, in_data);
  assign chk_crc  = dly_full ? crc_fold(base_crc, dly_q[0]) : base_crc;
  assign chk_cnt  = dly_full ? KW'(N + 1) : base_cnt + KW'(1);
  assign crc_fin  = crc_final(crc_q);

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = out_free && (state_q != S_APPEND);
  assign accept   = in_valid && in_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_dly
    if (gi == N - 1) begin : g_newest
      assign dly_shift[gi] = in_data;
    end else begin : g_older
      assign dly_shift[gi] = dly_q[gi+1];
    end
    // Oldest entry lands in the MS slice, matching the CRC emit order.
    assign dly_next_flat[(N-1-gi)*DATA_W +: DATA_W] = dly_shift[gi];
    assign crc_slice[gi] = crc_fin[(N-1-gi)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    app_d       = app_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = err_q;
    dly_we      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      mode_d      = eff_mode;
      if (!eff_mode) begin
        crc_d      = gen_crc;
        out_last_d = 1'b0;
        if (in_last) begin
          state_d = S_APPEND;
          app_d   = '0;
        end else begin
          state_d = S_DATA;
        end
      end else begin
        // The beat pushed out of the delay line is folded; the newest N
        // beats stay out of the CRC as the candidate trailer.
        crc_d      = chk_crc;
        cnt_d      = chk_cnt;
        dly_we     = 1'b1;
        out_last_d = in_last;
        if (in_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = (chk_cnt <= KW'(N)) ||
                    (dly_next_flat != crc_final(chk_crc));
        end else begin
          state_d = S_DATA;
        end
      end
    end else if ((state_q == S_APPEND) && out_free) begin
      out_valid_d = 1'b1;
      out_data_d  = crc_slice[app_q];
      out_last_d  = (app_q == AW'(N - 1));
      if (app_q == AW'(N - 1)) begin
        state_d = S_IDLE;
      end else begin
        app_d = app_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      crc_q       <= SEED;
      cnt_q       <= '0;
      app_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      app_q       <= app_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      if (dly_we) begin
        for (int i = 0; i < N; i++) begin
          dly_q[i] <= dly_shift[i];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign crc_done  = done_q;
  assign crc_err   = err_q;

endmodule

// File: tb/tb_lcrc32_stream.sv
// Testbench for lcrc32_stream. Three instances (DATA_W = 8, 16, 32) share
// the stimulus bus; sel picks which one sees in_valid and which one drives
// the observed outputs.
module tb_lcrc32_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, md, vld, lst, ordy;
  logic [31:0] dat;
  int          sel;

  logic       rdy8, ov8, ol8, dn8, er8;
  logic [7:0] od8;
  logic        rdy16, ov16, ol16, dn16, er16;
  logic [15:0] od16;
  logic        rdy32, ov32, ol32, dn32, er32;
  logic [31:0] od32;

  lcrc32_stream #(.DATA_W(8)) u_dw8 (
    .clk(clk), .reset(rst_n), .mode(md), .in_valid(vld && sel == 0),
    .in_ready(rdy8), .in_data(dat[7:0]), .in_last(lst),
    .out_valid(ov8), .out_ready(ordy), .out_data(od8), .out_last(ol8),
    .crc_done(dn8), .crc_err(er8));

  lcrc32_stream #(.DATA_W(16)) u_dw16 (
    .clk(clk), .reset(rst_n), .mode(md), .in_valid(vld && sel == 1),
    .in_ready(rdy16), .in_data(dat[15:0]), .in_last(lst),
    .out_valid(ov16), .out_ready(ordy), .out_data(od16), .out_last(ol16),
    .crc_done(dn16), .crc_err(er16));

  lcrc32_stream #(.DATA_W(32)) u_dw32 (
    .clk(clk), .reset(rst_n), .mode(md), .in_valid(vld && sel == 2),
    .in_ready(rdy32), .in_data(dat), .in_last(lst),
    .out_valid(ov32), .out_ready(ordy), .out_data(od32), .out_last(ol32),
    .crc_done(dn32), .crc_err(er32));

  logic        irdy, o_v, o_l, done, err;
  logic [31:0] o_d;
  assign irdy = (sel == 0) ? rdy8 : (sel == 1) ? rdy16 : rdy32;
  assign o_v  = (sel == 0) ? ov8  : (sel == 1) ? ov16  : ov32;
  assign o_l  = (sel == 0) ? ol8  : (sel == 1) ? ol16  : ol32;
  assign done = (sel == 0) ? dn8  : (sel == 1) ? dn16  : dn32;
  assign err  = (sel == 0) ? er8  : (sel == 1) ? er16  : er32;
  assign o_d  = (sel == 0) ? {24'h0, od8} : (sel == 1) ? {16'h0, od16} : od32;

  int n_total, n_bad;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [32:0] obs_q[$];
  logic        done_err_q[$];
  int          done_cyc_q[$];
  logic        done_last;
  int          irdy_low, stall_bad;
  logic        prev_stall;
  logic [31:0] prev_d;
  logic        prev_l;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (o_v && ordy) obs_q.push_back({o_l, o_d});
      if (done) begin
        done_err_q.push_back(err);
        done_cyc_q.push_back(cyc);
        done_last = o_v && o_l;
      end
      if (!irdy) irdy_low++;
      if (prev_stall && !(o_v && o_d == prev_d && o_l == prev_l)) stall_bad++;
      prev_stall = o_v && !ordy;
      prev_d     = o_d;
      prev_l     = o_l;
    end
  end

  // ---------------- packet helpers ----------------
  logic [7:0]  byte_q[$];
  logic [31:0] pkt_q[$];
  logic [32:0] exp_q[$];

  // Bit-serial LCRC over byte_q, returned in wire order (MS byte first).
  function automatic logic [31:0] crc_ref();
    logic [31:0] c, r;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (byte_q[n]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[31] ^ byte_q[n][i];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    c = ~c;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        r[8*k+i] = c[8*k+7-i];
    return r;
  endfunction

  task automatic pack(input int w);
    logic [31:0] b;
    pkt_q.delete();
    for (int i = 0; i < byte_q.size(); i += w / 8) begin
      b = 32'h0;
      for (int j = 0; j < w / 8; j++) b = (b << 8) | {24'h0, byte_q[i+j]};
      pkt_q.push_back(b);
    end
  endtask

  // Check-mode expectation: packet forwarded as-is, last on final beat.
  task automatic exp_fwd();
    exp_q.delete();
    foreach (pkt_q[i]) exp_q.push_back({(i == pkt_q.size() - 1), pkt_q[i]});
  endtask

  // Generate-mode expectation from the model CRC of byte_q.
  task automatic exp_gen(input int w);
    logic [31:0] crc, mask;
    int          n;
    crc  = crc_ref();
    n    = 32 / w;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
    exp_q.delete();
    foreach (pkt_q[i]) exp_q.push_back({1'b0, pkt_q[i]});
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == n - 1), (crc >> (32 - w * (k + 1))) & mask});
  endtask

  task automatic append_ref_crc();
    logic [31:0] crc;
    crc = crc_ref();
    byte_q.push_back(crc[31:24]);
    byte_q.push_back(crc[23:16]);
    byte_q.push_back(crc[15:8]);
    byte_q.push_back(crc[7:0]);
  endtask

  task automatic digits(input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'h31 + 8'(i));
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit acc;
    int t;
    vld = 1'b1; dat = d; lst = l; acc = 1'b0; t = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = irdy;
      @(posedge clk);
      #1;
      t++;
    end
    vld = 1'b0; lst = 1'b0;
    if (!acc) chk_eq("accept_timeout", 64'(t), 64'd0);
  endtask

  task automatic send_pkt(input logic m);
    md = m;
    for (int i = 0; i < pkt_q.size(); i++) send_beat(pkt_q[i], i == pkt_q.size() - 1);
    $display("tx sel=%0d mode=%0d beats=%0d", sel, m, pkt_q.size());
  endtask

  task automatic expect_stream(input string tag);
    int t;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk_eq({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk_eq($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic check_verdict(input string tag, input logic exp_err);
    chk_eq({tag, "_ndone"}, 64'(done_err_q.size()), 64'd1);
    if (done_err_q.size() > 0) chk_eq({tag, "_err"}, 64'(done_err_q[0]), 64'(exp_err));
    chk_eq({tag, "_done_with_last"}, 64'(done_last), 64'd1);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    done_err_q.delete();
    done_cyc_q.delete();
    done_last = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0; md = 1'b0; vld = 1'b0; lst = 1'b0; dat = '0; ordy = 1'b1;
    sel = 0; n_total = 0; n_bad = 0; irdy_low = 0; stall_bad = 0;
    done_last = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_eq($sformatf("rst%0d_in_ready", s),  64'(irdy), 64'd1);
      chk_eq($sformatf("rst%0d_out_valid", s), 64'(o_v),  64'd0);
      chk_eq($sformatf("rst%0d_out_data", s),  64'(o_d),  64'd0);
      chk_eq($sformatf("rst%0d_out_last", s),  64'(o_l),  64'd0);
      chk_eq($sformatf("rst%0d_crc_done", s),  64'(done), 64'd0);
      chk_eq($sformatf("rst%0d_crc_err", s),   64'(err),  64'd0);
    end
    rst_n = 1'b1;
    sel = 0;
    @(posedge clk);
    #1;

    // Generate, 8-bit, "123456789": hand-known trailer 26 39 F4 CB.
    clear_obs();
    irdy_low = 0;
    digits(9);
    pack(8);
    exp_q.delete();
    foreach (pkt_q[i]) exp_q.push_back({1'b0, pkt_q[i]});
    exp_q.push_back({1'b0, 32'h26});
    exp_q.push_back({1'b0, 32'h39});
    exp_q.push_back({1'b0, 32'hF4});
    exp_q.push_back({1'b1, 32'hCB});
    send_pkt(1'b0);
    expect_stream("gen8");
    chk_eq("gen8_in_ready_low_cycles", 64'(irdy_low), 64'd4);

    // Generate, 32-bit, "12345678": single append beat.
    sel = 2;
    clear_obs();
    digits(8);
    pack(32);
    exp_gen(32);
    send_pkt(1'b0);
    expect_stream("gen32");

    // Generate, 8-bit, single-beat packet "A".
    sel = 0;
    clear_obs();
    byte_q.delete();
    byte_q.push_back(8'h41);
    pack(8);
    exp_gen(8);
    send_pkt(1'b0);
    expect_stream("gen8_one");

    // Check, 8-bit, "123456789" + 26 39 F4 CB -> good.
    clear_obs();
    digits(9);
    byte_q.push_back(8'h26); byte_q.push_back(8'h39);
    byte_q.push_back(8'hF4); byte_q.push_back(8'hCB);
    pack(8);
    exp_fwd();
    send_pkt(1'b1);
    expect_stream("chk8_good");
    check_verdict("chk8_good", 1'b0);

    // Same packet with bit 0 of 0x35 flipped -> error.
    clear_obs();
    byte_q[4] = 8'h34;
    pack(8);
    exp_fwd();
    send_pkt(1'b1);
    expect_stream("chk8_bad");
    check_verdict("chk8_bad", 1'b1);

    // Check, 32-bit: "12345678" + model trailer -> good.
    sel = 2;
    clear_obs();
    digits(8);
    append_ref_crc();
    pack(32);
    exp_fwd();
    send_pkt(1'b1);
    expect_stream("chk32_good");
    check_verdict("chk32_good", 1'b0);

    // Backpressure, 16-bit generate: out_ready toggles through payload and append.
    sel = 1;
    clear_obs();
    stall_bad = 0;
    digits(8);
    pack(16);
    exp_gen(16);
    fork
      send_pkt(1'b0);
      begin
        ordy = 1'b0;
        repeat (30) begin
          @(posedge clk);
          #1;
          ordy = ~ordy;
        end
        ordy = 1'b1;
      end
    join
    expect_stream("bp16");
    chk_eq("bp16_stall_stable", 64'(stall_bad), 64'd0);

    // Short check packet, 3 beats -> error verdict.
    sel = 0;
    clear_obs();
    digits(3);
    pack(8);
    exp_fwd();
    send_pkt(1'b1);
    expect_stream("chk8_short");
    check_verdict("chk8_short", 1'b1);

    // Back-to-back check packets: 13 beats then 12 beats, no idle between.
    clear_obs();
    digits(9);
    byte_q.push_back(8'h26); byte_q.push_back(8'h39);
    byte_q.push_back(8'hF4); byte_q.push_back(8'hCB);
    pack(8);
    send_pkt(1'b1);
    digits(8);
    append_ref_crc();
    pack(8);
    send_pkt(1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk_eq("b2b_ndone", 64'(done_err_q.size()), 64'd2);
    if (done_err_q.size() == 2) begin
      chk_eq("b2b_err0", 64'(done_err_q[0]), 64'd0);
      chk_eq("b2b_err1", 64'(done_err_q[1]), 64'd0);
      chk_eq("b2b_gap", 64'(done_cyc_q[1] - done_cyc_q[0]), 64'd12);
    end

    // Reset while the second CRC beat is presented.
    clear_obs();
    digits(9);
    pack(8);
    send_pkt(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_eq("abort_pre_data", 64'(o_d), 64'h39);
    chk_eq("abort_pre_valid", 64'(o_v), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("abort_out_valid", 64'(o_v),  64'd0);
    chk_eq("abort_out_data",  64'(o_d),  64'd0);
    chk_eq("abort_out_last",  64'(o_l),  64'd0);
    chk_eq("abort_in_ready",  64'(irdy), 64'd1);
    chk_eq("abort_crc_done",  64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_obs();
    digits(8);
    pack(8);
    exp_gen(8);
    send_pkt(1'b0);
    expect_stream("post_abort");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1);
  end

endmodule

// File: doc/lcrc32_stream.md
# lcrc32_stream

Streaming, parametrised LCRC-32 generator/checker for the replay-buffer datapath. It accepts a packet as a sequence of DATA_W-bit beats over a valid/ready handshake and computes the PCIe-style LCRC-32 incrementally, one beat per cycle. In generate mode it forwards the payload and appends the 32-bit LCRC as trailing beats. In check mode it forwards the packet unchanged and flags whether the trailing 32 bits match the CRC of the preceding payload.

## Interface
- DATA_W, 32, beat width in bits; legal values 8, 16, 32.
- POLY, 32'h04C11DB7, generator polynomial.
- SEED, 32'hFFFFFFFF, CRC register value at packet start.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  reset; asynchronous, active-low.
- mode  in  1  0 = generate/append, 1 = check; sampled on the first accepted beat of each packet.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  input beat.
- in_last  in  1  final beat of packet.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  output beat.
- out_last  out  1  final output beat of packet.
- crc_done  out  1  one-cycle pulse: check-mode verdict valid.
- crc_err  out  1  check-mode mismatch; valid with crc_done, held until the next crc_done.

## Operation
- N = 32/DATA_W CRC beats.
- CRC per beat: bytes are processed most-significant byte first. Within a byte, bit 0 is processed first. For each bit b: fb = c[31]^b; c = (c<<1) ^ (fb ? POLY : 0).
- Final CRC value: each byte of ~c is bit-reversed, so result bit [8k+i] = ~c[8k+7-i]. It is emitted most-significant DATA_W slice first.
- FSM states:
  - IDLE: waiting for the first beat. On acceptance, latch mode, load c = SEED, then fold the beat.
  - DATA: fold each accepted beat. If in_last is accepted in generate mode, go to APPEND; in check mode, go to IDLE.
  - APPEND: emit N CRC beats, out_last on the final one, then go to IDLE. in_ready = 0 throughout.
- Generate mode: payload beats are forwarded unchanged with out_last = 0. The packet's out_last falls on the last CRC beat.
- Check mode, data path: beats are forwarded unchanged and out_last follows in_last.
- Check mode, CRC path: an N-entry delay line holds the most recent N beats. A beat is folded into c only when it is pushed out by a newer beat, so the last N beats are never folded.
- Check mode, verdict: on in_last, compare the delay-line contents (oldest = MS slice) against the final CRC value of c. Pulse crc_done and set crc_err = mismatch.
- Short check packet: fewer than N+1 beats gives crc_done = 1, crc_err = 1.
- A mode change mid-packet is ignored.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_last 0, crc_done 0, crc_err 0, state IDLE, c = SEED, delay line cleared.
- Reset mid-packet discards the partial packet. The first beat after reset release starts a new packet.
- Single registered output stage. in_ready = (!out_valid | out_ready) & (state != APPEND).
- Latency: an accepted beat appears on out_data the next cycle.
- Generate mode:
  - The first CRC beat is presented the cycle after the in_last beat leaves the output register.
  - Throughput is one beat per cycle absent backpressure.
  - A new packet may be accepted the cycle after the last CRC beat handshakes.
- Check mode: crc_done asserts the cycle after in_last is accepted, which is the same cycle out_last is first presented. Back-to-back packets run with zero bubble.
- Holding rule: out_valid/out_data/out_last hold stable while out_valid & !out_ready.
- The CRC fold of one DATA_W beat is a single-cycle combinational unroll.

## Test plan
- Generate, DATA_W=8, bytes 31..39 ("123456789"), out_ready=1 -> 9 payload bytes then 26 39 F4 CB, out_last on CB; in_ready low for 4 cycles.
- Generate, DATA_W=32, beats 31323334, 35363738, then 39 padded case omitted; use 8-byte 3132333435363738 -> CRC beat equals reference model output; one append beat.
- Check, DATA_W=8, "123456789"+26 39 F4 CB -> crc_done pulse with crc_err=0; flip bit 0 of 0x35 -> crc_err=1.
- Backpressure, DATA_W=16: out_ready toggles 1010... during payload and APPEND -> identical beat sequence, out_data stable while stalled, no beat lost or duplicated.
- Short check packet, DATA_W=8, 3 beats -> crc_done=1, crc_err=1. Back-to-back check packets -> two verdicts with no idle cycle.
- Assert reset (low) during APPEND beat 2 -> outputs at reset values immediately; the next packet's CRC is independent of the aborted one.
